// File: rtl/vit_pkg.sv
// Shared Viterbi types: trellis geometry, metric array, path metric FSM states and the
// minimum-search tree node.
package vit_pkg;

  localparam int unsigned NUM_STATES = 8;
  localparam int unsigned METRIC_W   = 8;
  localparam int unsigned IDX_W      = 3;

  typedef logic [METRIC_W-1:0] metric_t;

  // Packed so that element s sits at bits [8s+7:8s] of the flat 64-bit bus.
  typedef metric_t [NUM_STATES-1:0] metric_arr_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } pmu_state_e;

  typedef struct packed {
    logic             vld;
    metric_t          metric;
    logic [IDX_W-1:0] idx;
  } min_node_t;

  // The left operand always carries the lower state index, so it wins ties and the
  // all-invalid case, which keeps index 0 as the default answer.
  function automatic min_node_t min_merge(input min_node_t l, input min_node_t r);
    logic take_r;
    take_r = r.vld && (!l.vld || (r.metric < l.metric));
    return take_r ? r : l;
  endfunction

  // True when every valid entry has its MSB set; vacuously true with no valid entries.
  function automatic logic all_valid_msb_set(input metric_arr_t cost,
                                             input logic [NUM_STATES-1:0] vld);
    logic res;
    res = 1'b1;
    for (int s = 0; s < NUM_STATES; s++) begin
      if (vld[s] && !cost[s][METRIC_W-1]) begin
        res = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/min_select.sv
// Combinational three-level tree returning the lowest index among the minimum valid
// metrics; returns 0 when no metric is valid.
module min_select
  import vit_pkg::*;
(
  input  metric_arr_t           i_metric,
  input  logic [NUM_STATES-1:0] i_valid,
  output logic [IDX_W-1:0]      o_idx
);

  min_node_t w_leaf [NUM_STATES];
  min_node_t w_lvl1 [NUM_STATES/2];
  min_node_t w_lvl2 [NUM_STATES/4];
  min_node_t w_root;

  always_comb begin
    for (int s = 0; s < NUM_STATES; s++) begin
      w_leaf[s].vld    = i_valid[s];
      w_leaf[s].metric = i_metric[s];
      w_leaf[s].idx    = IDX_W'(s);
    end
    for (int n = 0; n < NUM_STATES / 2; n++) begin
      w_lvl1[n] = min_merge(w_leaf[2*n], w_leaf[2*n+1]);
    end
    for (int n = 0; n < NUM_STATES / 4; n++) begin
      w_lvl2[n] = min_merge(w_lvl1[2*n], w_lvl1[2*n+1]);
    end
    w_root = min_merge(w_lvl2[0], w_lvl2[1]);
  end

  assign o_idx = w_root.vld ? w_root.idx : '0;

endmodule

// File: rtl/path_metric_unit.sv
// Path metric register bank and frame sequencer for an 8-state Viterbi decoder.
// Define PMU_NORM_EN to subtract 128 from all valid metrics when every one has its MSB set.
module path_metric_unit
  import vit_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           acs_en,
  input  logic [NUM_STATES-1:0]          acs_valid,
  input  logic [NUM_STATES*METRIC_W-1:0] acs_cost,
  input  logic [NUM_STATES-1:0]          acs_sel,
  output logic [NUM_STATES*METRIC_W-1:0] pm,
  output logic [NUM_STATES-1:0]          pm_valid,
  output logic [NUM_STATES-1:0]          sel_o,
  output logic                           sel_valid,
  output logic                           done,
  output logic [IDX_W-1:0]               best_state
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(FRAME_LEN - 1);

  pmu_state_e            r_state, w_state_d;
  metric_arr_t           r_pm, w_pm_d;
  logic [NUM_STATES-1:0] r_pm_valid, w_pm_valid_d;
  logic [NUM_STATES-1:0] r_sel, w_sel_d;
  logic                  r_sel_valid, w_sel_valid_d;
  logic [CNT_W-1:0]      r_cnt, w_cnt_d;

  metric_arr_t           w_cost_raw;
  metric_arr_t           w_cost_in;
  logic [IDX_W-1:0]      w_min_idx;

  assign w_cost_raw = metric_arr_t'(acs_cost);

  always_comb begin
    w_cost_in = '0;
    for (int s = 0; s < NUM_STATES; s++) begin
      if (acs_valid[s]) begin
        w_cost_in[s] = w_cost_raw[s];
      end
    end
`ifdef PMU_NORM_EN
    // Clearing the MSB is the same as subtracting 128 once it is known to be set.
    if (all_valid_msb_set(w_cost_raw, acs_valid)) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        if (acs_valid[s]) begin
          w_cost_in[s][METRIC_W-1] = 1'b0;
        end
      end
    end
`endif
  end

  always_comb begin
    w_state_d     = r_state;
    w_pm_d        = r_pm;
    w_pm_valid_d  = r_pm_valid;
    w_sel_d       = r_sel;
    w_sel_valid_d = 1'b0;
    w_cnt_d       = r_cnt;

    if (start) begin
      w_state_d    = StRun;
      w_pm_d       = '0;
      w_pm_valid_d = NUM_STATES'(1);
      w_cnt_d      = '0;
    end else begin
      case (r_state)
        StIdle: begin
          w_state_d = StIdle;
        end
        StRun: begin
          if (acs_en) begin
            w_pm_d        = w_cost_in;
            w_pm_valid_d  = acs_valid;
            w_sel_d       = acs_sel;
            w_sel_valid_d = 1'b1;
            w_cnt_d       = r_cnt + CNT_W'(1);
            if (r_cnt == CntLast) begin
              w_state_d = StDone;
            end
          end
        end
        StDone: begin
          w_state_d = StIdle;
        end
        default: begin
          w_state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_pm        <= '0;
      r_pm_valid  <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pm        <= w_pm_d;
      r_pm_valid  <= w_pm_valid_d;
      r_sel       <= w_sel_d;
      r_sel_valid <= w_sel_valid_d;
      r_cnt       <= w_cnt_d;
    end
  end

  min_select u_min_select (
    .i_metric (r_pm),
    .i_valid  (r_pm_valid),
    .o_idx    (w_min_idx)
  );

  assign pm         = r_pm;
  assign pm_valid   = r_pm_valid;
  assign sel_o      = r_sel;
  assign sel_valid  = r_sel_valid;
  assign done       = (r_state == StDone);
  assign best_state = done ? w_min_idx : '0;

endmodule
